// File: rtl/rand_arbiter_pkg.sv
// Shared types and constants for the random-value arbiter and its LFSR.
package rand_arbiter_pkg;

    localparam int unsigned LFSR_W = 10;
    localparam int unsigned TAP_HI = 9;
    localparam int unsigned TAP_LO = 6;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StGrant
    } state_e;

endpackage

// File: rtl/lfsr10.sv
// 10-bit XNOR Fibonacci LFSR; XNOR feedback makes all-zero the legal reset state
// and all-ones the lock-up state.
module lfsr10
    import rand_arbiter_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              en,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] r_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= {r_q[LFSR_W-2:0], ~(r_q[TAP_HI] ^ r_q[TAP_LO])};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin arbiter handing out LFSR values; the LFSR runs SETTLE cycles
// between the grant decision and the delivery of the captured value.
module rand_arbiter
    import rand_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned SETTLE = 10
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  grant,
    output logic [LFSR_W-1:0] rnd,
    output logic              rnd_valid,
    output logic              busy,
    output logic [LFSR_W-1:0] lfsr_q
);

    localparam int unsigned      IDX_W    = $clog2(N_REQ);
    localparam int unsigned      CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    state_e            r_state, w_state_d;
    logic [IDX_W-1:0]  r_winner, w_winner_d;
    logic [IDX_W-1:0]  r_last, w_last_d;
    logic [IDX_W-1:0]  w_pick;
    logic              w_found;
    logic [CNT_W-1:0]  r_cnt, w_cnt_d;
    logic [LFSR_W-1:0] r_rnd, w_rnd_d;
    logic [LFSR_W-1:0] w_lfsr;

    lfsr10 u_lfsr (
        .Clock (Clock),
        .Reset (Reset),
        .en    (1'b1),
        .q     (w_lfsr)
    );

    // Search starts just after the last served index and wraps.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            if (!w_found && req[IDX_W'((32'(r_last) + i) % N_REQ)]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'((32'(r_last) + i) % N_REQ);
            end
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_winner_d = r_winner;
        w_last_d   = r_last;
        w_cnt_d    = r_cnt;
        w_rnd_d    = r_rnd;
        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_winner_d = w_pick;
                    w_cnt_d    = CNT_LOAD;
                    w_state_d  = StSettle;
                end
            end
            StSettle: begin
                if (!req[r_winner]) begin
                    w_state_d = StIdle;
                end else if (r_cnt == '0) begin
                    w_state_d = StGrant;
                    w_rnd_d   = w_lfsr;
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            StGrant: begin
                w_last_d  = r_winner;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= StIdle;
            r_winner <= '0;
            r_last   <= LAST_RST;
            r_cnt    <= '0;
            r_rnd    <= '0;
        end else begin
            r_state  <= w_state_d;
            r_winner <= w_winner_d;
            r_last   <= w_last_d;
            r_cnt    <= w_cnt_d;
            r_rnd    <= w_rnd_d;
        end
    end

    always_comb begin
        grant = '0;
        if (r_state == StGrant) begin
            grant[r_winner] = 1'b1;
        end
    end

    assign rnd_valid = (r_state == StGrant);
    assign busy      = (r_state != StIdle);
    assign rnd       = r_rnd;
    assign lfsr_q    = w_lfsr;

endmodule

// File: tb/tb_rand_arbiter.sv
// Scoreboard bench for rand_arbiter: a cycle-level reference model pushes expected
// grants; a negedge monitor pops and compares them against the DUT outputs.
module tb_rand_arbiter;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned SETTLE = 10;

    logic             Clock = 1'b0;
    logic             Reset = 1'b1;
    logic [N_REQ-1:0] req   = '0;
    logic [N_REQ-1:0] grant;
    logic [9:0]       rnd;
    logic [9:0]       lfsr_q;
    logic             rnd_valid;
    logic             busy;

    rand_arbiter #(
        .N_REQ  (N_REQ),
        .SETTLE (SETTLE)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .req       (req),
        .grant     (grant),
        .rnd       (rnd),
        .rnd_valid (rnd_valid),
        .busy      (busy),
        .lfsr_q    (lfsr_q)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int               cyc;
        logic [N_REQ-1:0] g;
        logic [9:0]       r;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;

    // Reference model state: values as seen during the current cycle.
    logic [9:0] m_lfsr = '0;
    logic [9:0] m_rnd  = '0;
    bit         m_pend = 1'b0;
    bit         m_ingrant = 1'b0;
    bit         m_busy = 1'b0;
    int         m_win  = 0;
    int         m_last = N_REQ - 1;
    int         m_dec  = 0;
    int         m_cycle = 0;

    function automatic logic [9:0] lfsr_next(input logic [9:0] q);
        return {q[8:0], ~(q[9] ^ q[6])};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, m_cycle);
        end
    endtask

    // Applies the arbitration rules for the cycle that just ended.
    task automatic model_edge();
        logic [N_REQ-1:0] oh;
        bit               found;
        int               idx;
        if (Reset) begin
            m_lfsr    = '0;
            m_rnd     = '0;
            m_last    = N_REQ - 1;
            m_pend    = 1'b0;
            m_ingrant = 1'b0;
            exp_q.delete();
        end else begin
            if (m_ingrant) begin
                m_last    = m_win;
                m_ingrant = 1'b0;
            end else if (m_pend) begin
                if (!req[m_win]) begin
                    m_pend = 1'b0;
                end else if (m_cycle == m_dec + int'(SETTLE)) begin
                    oh        = '0;
                    oh[m_win] = 1'b1;
                    m_rnd     = m_lfsr;
                    m_pend    = 1'b0;
                    m_ingrant = 1'b1;
                    exp_q.push_back('{cyc: m_cycle + 1, g: oh, r: m_lfsr});
                end
            end else if (req != '0) begin
                found = 1'b0;
                for (int i = 1; i <= int'(N_REQ); i++) begin
                    idx = (m_last + i) % int'(N_REQ);
                    if (!found && req[idx]) begin
                        found = 1'b1;
                        m_win = idx;
                    end
                end
                m_pend = 1'b1;
                m_dec  = m_cycle;
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
        m_busy = m_pend || m_ingrant;
        m_cycle++;
    endtask

    task automatic tick();
        @(posedge Clock);
        model_edge();
        @(negedge Clock);
    endtask

    task automatic wait_grant(input int idx, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            tick();
            if (grant[idx] === 1'b1) begin
                seen   = 1'b1;
                req[idx] = 1'b0;
            end
        end
        check("wait_grant", 32'(seen), 32'd1);
    endtask

    always @(negedge Clock) begin
        if (chk_en) begin
            check("lfsr_q", 32'(lfsr_q), 32'(m_lfsr));
            check("busy", 32'(busy), 32'(m_busy));
            check("rnd", 32'(rnd), 32'(m_rnd));
            if (rnd_valid === 1'b1) begin
                check("grant_queued", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("grant_vec", 32'(grant), 32'(mon_e.g));
                    check("grant_cycle", 32'(m_cycle), 32'(mon_e.cyc));
                    check("grant_rnd", 32'(rnd), 32'(mon_e.r));
                end
            end else begin
                check("grant_idle", 32'(grant), 32'd0);
                if (exp_q.size() > 0 && exp_q[0].cyc <= m_cycle) begin
                    check("rnd_valid_due", 32'(rnd_valid), 32'd1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    logic [9:0] seq [12] = '{10'h000, 10'h001, 10'h003, 10'h007, 10'h00F, 10'h01F,
                             10'h03F, 10'h07F, 10'h0FE, 10'h1FC, 10'h3F8, 10'h3F1};

    initial begin
        logic [9:0] v0;
        int         period;
        int         lock_hits;

        Reset = 1'b1;
        req   = '0;
        repeat (3) tick();
        chk_en = 1'b1;
        check("rst_lfsr", 32'(lfsr_q), 32'd0);
        check("rst_rnd", 32'(rnd), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_valid", 32'(rnd_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        Reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            check("lfsr_seq", 32'(lfsr_q), 32'(seq[k]));
            tick();
        end

        // Single requester: latency and captured value come from the model.
        req = 4'b0001;
        wait_grant(0, SETTLE + 4);
        repeat (2) tick();

        // All requesting: rotation 0,1,2,3,0.
        req = 4'b1111;
        repeat (5 * (SETTLE + 2) + 2) tick();
        req = '0;
        repeat (SETTLE + 4) tick();

        // Winner drops mid-settle: abort, no grant.
        req = 4'b0100;
        repeat (5) tick();
        req = '0;
        repeat (2) tick();
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_nogrant", 32'(grant), 32'd0);

        // Reset mid-settle.
        req = 4'b0001;
        repeat (4) tick();
        Reset = 1'b1;
        tick();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_lfsr", 32'(lfsr_q), 32'd0);
        check("midrst_rnd", 32'(rnd), 32'd0);
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_valid", 32'(rnd_valid), 32'd0);
        Reset = 1'b0;
        req   = 4'b1001;
        wait_grant(0, SETTLE + 4);
        wait_grant(3, 2 * SETTLE + 6);
        repeat (2) tick();
        req = 4'b1000;
        wait_grant(3, SETTLE + 4);
        repeat (2) tick();

        // Randomized traffic with occasional request withdrawal.
        for (int k = 0; k < 800; k++) begin
            tick();
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (req[i] && grant[i] === 1'b1) begin
                    req[i] = 1'b0;
                end else if (!req[i] && ($urandom % 6) == 0) begin
                    req[i] = 1'b1;
                end else if (req[i] && ($urandom % 60) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        req = '0;
        repeat (SETTLE + 4) tick();

        // Free-running LFSR: period and lock-up.
        v0        = lfsr_q;
        period    = 0;
        lock_hits = 0;
        for (int k = 1; k <= 2000; k++) begin
            tick();
            if (lfsr_q === 10'h3FF) lock_hits++;
            if (period == 0 && lfsr_q === v0) period = k;
        end
        check("lfsr_lockup", 32'(lock_hits), 32'd0);
        check("lfsr_period", 32'(period), 32'd1023);

        repeat (4) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rand_arbiter.md
RAND_ARBITER -- requirements
Module: rand_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8) SHALL be supported.
REQ-002 Parameter SETTLE, default 10, LFSR advance cycles between grant decision and delivery, SHALL be >= 1.
REQ-003 Clock  input  1  rising-edge clock.
REQ-004 Reset  input  1  reset, synchronous, active-high.
REQ-005 req  input  N_REQ  per-requester random-value request, level, held until granted.
REQ-006 grant  output  N_REQ  one-hot, one-cycle pulse to the served requester.
REQ-007 rnd  output  10  delivered random value.
REQ-008 rnd_valid  output  1  high in the same cycle as grant.
REQ-009 busy  output  1  high whenever the FSM is not IDLE.
REQ-010 lfsr_q  output  10  current LFSR state, for debug.

Function
REQ-011 The LFSR SHALL be 10 bits, with next = {q[8:0], ~(q[9]^q[6])}, advancing every cycle Reset is low.
REQ-012 The FSM SHALL have three states: IDLE, SETTLE, GRANT.
REQ-013 IDLE: if any req bit is high, the winner SHALL be latched, the counter loaded with SETTLE-1, and the FSM SHALL go to SETTLE; otherwise it stays in IDLE.
REQ-014 Arbitration SHALL be round-robin: the search starts at index last_grant+1 and wraps from N_REQ-1 to 0; after reset, last_grant = N_REQ-1, so index 0 has top priority.
REQ-015 SETTLE: the counter SHALL decrement each cycle; at 0 the FSM SHALL go to GRANT and capture rnd <= lfsr_q on that edge.
REQ-016 GRANT: grant[winner]=1 and rnd_valid=1 for exactly one cycle; last_grant SHALL be set to winner; the next state SHALL be IDLE.
REQ-017 Latency: req seen in IDLE at cycle t SHALL produce grant in cycle t+1+SETTLE; the minimum grant spacing SHALL be SETTLE+2 cycles.
REQ-018 If the winner's req drops during SETTLE, the FSM SHALL abort to IDLE with no grant; rnd and last_grant SHALL be unchanged.
REQ-019 Requests arriving during SETTLE/GRANT SHALL wait; they SHALL NOT alter the latched winner.
REQ-020 rnd SHALL hold its value between grants; grant SHALL be all zero outside GRANT.
REQ-021 All outputs SHALL be registered or decoded from state only; there SHALL be no combinational path from req to outputs.

Reset
REQ-022 Reset SHALL override every other event, including mid-SETTLE and in GRANT.
REQ-023 Reset values SHALL be: state=IDLE, lfsr_q=0, rnd=0, rnd_valid=0, grant=0, busy=0, counter=0, last_grant=N_REQ-1.
REQ-024 The LFSR lock-up state 3FF SHALL NOT be reachable from reset.

Structure
REQ-025 Package rand_arbiter_pkg SHALL hold the FSM state enum, LFSR_W=10, and the tap indices 9 and 6.
REQ-026 The LFSR SHALL be the sub-module lfsr10 (ports Clock, Reset, en, q); rand_arbiter SHALL tie en=1.

Verification
REQ-027 Release Reset with req=0: lfsr_q SHALL step 000,001,003,007,00F,01F,03F,07F,0FE,1FC,3F8,3F1.
REQ-028 SETTLE=10, req=0001 at cycle t in IDLE: grant=0001 and rnd_valid in cycle t+11; rnd SHALL equal lfsr_q of cycle t+10.
REQ-029 req=1111 held continuously: grants SHALL be 0001,0010,0100,1000,0001, spaced 12 cycles apart.
REQ-030 req[2] alone, dropped mid-SETTLE: no grant, FSM back to IDLE, rnd unchanged.
REQ-031 Reset asserted during SETTLE: the next cycle SHALL show all REQ-023 values; after release, req=1000 SHALL be served before index 0 only if it is the sole requester.
REQ-032 Run 2000 cycles without Reset: lfsr_q SHALL never equal 3FF, and its period SHALL be 1023.
